div: RTL and testbench

Multi-cycle signed 32-bit integer divider: the inverse operation of the multiplier in the processor's multdiv unit. It computes `data_operandA / data_operandB` with one restoring-division iteration per clock, using a start pulse and a ready pulse with the same protocol as the multiplier. This lets the execute stage stall on either unit identically. The quotient is truncated toward zero. Divide-by-zero and signed overflow raise `data_exception`.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_iter.sv | 26 ++
 rtl/div.sv | 147 ++++++++++++++
 tb/tb_div.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the div block.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_iter.sv
// One combinational restoring-division step on magnitudes: shift {R,Q}, trial-subtract |B|.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_absb,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_r_sh;
    logic [WIDTH:0] w_trial;

    // Shifted remainder kept at WIDTH+1 bits so |min_int| as divisor loses nothing.
    assign w_r_sh  = {i_r, i_q[WIDTH-1]};
    assign w_trial = w_r_sh - {1'b0, i_absb};

    always_comb begin
        o_r = w_trial[WIDTH] ? w_r_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
        o_q = {i_q[WIDTH-2:0], ~w_trial[WIDTH]};
    end

endmodule

// File: rtl/div.sv
// div: multi-cycle signed integer divider, one restoring iteration per clock, start/ready pulses.
// Define DIV_REMAINDER_EN to build the signed data_remainder output.
//
//   state | meaning
//   IDLE  | waiting for ctrl_DIV
//   RUN   | WIDTH restoring iterations, r_cnt = 0..WIDTH-1
//   FIX   | apply signs / exception override, pulse ready
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
`ifdef DIV_REMAINDER_EN
   ,output logic [WIDTH-1:0] data_remainder
`endif
);

    localparam int CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_absb;
    logic             r_sign_q;
    logic             r_dz;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic             r_rdy;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_min_int;
    logic             w_ovf;
    logic             w_err;
    logic [WIDTH-1:0] w_iter_r;
    logic [WIDTH-1:0] w_iter_q;

    // Unsigned magnitudes: -min_int wraps to 2^(WIDTH-1), which is exactly |min_int|.
    assign w_abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign w_min_int = {1'b1, {(WIDTH-1){1'b0}}};
    assign w_ovf     = (data_operandA == w_min_int) && (data_operandB == {WIDTH{1'b1}});
    assign w_err     = r_dz | r_ovf;

    div_iter #(.WIDTH(WIDTH)) u_iter (
        .i_r    (r_rem),
        .i_q    (r_quo),
        .i_absb (r_absb),
        .o_r    (w_iter_r),
        .o_q    (w_iter_q)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ctrl_DIV) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                RUN:     if (r_cnt == LAST_CNT) w_state_nxt = FIX;
                FIX:     w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

`ifdef DIV_REMAINDER_EN
    logic             r_sign_r;
    logic [WIDTH-1:0] r_remainder;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sign_r    <= 1'b0;
            r_remainder <= '0;
        end else if (ctrl_DIV) begin
            r_sign_r    <= data_operandA[WIDTH-1];
        end else if (r_state == FIX) begin
            r_remainder <= w_err ? '0 : (r_sign_r ? -r_rem : r_rem);
        end
    end

    assign data_remainder = r_remainder;
`endif

    // A start always wins, including over RUN and FIX, so an abort never pulses ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_absb   <= '0;
            r_sign_q <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (ctrl_DIV) begin
                r_cnt    <= '0;
                r_rem    <= '0;
                r_quo    <= w_abs_a;
                r_absb   <= w_abs_b;
                r_sign_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_dz     <= (data_operandB == '0);
                r_ovf    <= w_ovf;
            end else begin
                case (r_state)
                    RUN: begin
                        r_rem <= w_iter_r;
                        r_quo <= w_iter_q;
                        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
                    end
                    FIX: begin
                        r_result <= w_err ? '0 : (r_sign_q ? -r_quo : r_quo);
                        r_exc    <= w_err;
                        r_rdy    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: scoreboard of reference-model results popped on each ready pulse.
module tb_div;

    localparam int W = 32;
    localparam int LATENCY = W + 1;
    localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

    logic         clock = 1'b0;
    logic         reset_n;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
`ifdef DIV_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] rem;
        int           start;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_rdy    = 0;
    logic prev_rdy = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    div #(.WIDTH(W)) u_div (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
`ifdef DIV_REMAINDER_EN
       ,.data_remainder (data_remainder)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        exp_t e;
        e.start = 0;
        if (b == 0 || (a == MIN_INT && b == -1)) begin
            e.res = '0;
            e.exc = 1'b1;
            e.rem = '0;
        end else begin
            e.res = a / b;
            e.rem = a % b;
            e.exc = 1'b0;
        end
        return e;
    endfunction

    // Drives the start for the next rising edge; caller must be between edges.
    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit abort);
        exp_t e;
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        if (abort) sb_q.delete();
        e       = model(a, b);
        e.start = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_rdy(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < LATENCY + 20 && !seen; i++) begin
            @(negedge clock);
            if (data_resultRDY) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, '0, 1);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (prev_rdy) chk("rdy_one_cycle", W'(data_resultRDY), '0);
        prev_rdy = data_resultRDY;
        if (data_resultRDY) begin
            n_rdy++;
            if (sb_q.size() == 0) begin
                chk("unexpected_rdy", 1, '0);
            end else begin
                e = sb_q.pop_front();
                chk("result", data_result, e.res);
                chk("exception", W'(data_exception), W'(e.exc));
                chk("latency", W'(cyc - e.start), W'(LATENCY));
`ifdef DIV_REMAINDER_EN
                chk("remainder", data_remainder, e.rem);
`endif
            end
        end
    end

    logic [W-1:0] dir_a [8] = '{32'd100, -32'sd7, 32'd7, 32'd123, MIN_INT, MIN_INT, 32'd0, -32'sd100};
    logic [W-1:0] dir_b [8] = '{32'd7, 32'd2, -32'sd2, 32'd0, {W{1'b1}}, 32'd1, 32'd5, -32'sd7};

    initial begin
        int           rdy_before;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset_n       = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #1;
        chk("reset_result", data_result, '0);
        chk("reset_exception", W'(data_exception), '0);
        chk("reset_rdy", W'(data_resultRDY), '0);
`ifdef DIV_REMAINDER_EN
        chk("reset_remainder", data_remainder, '0);
`endif
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            start_div(dir_a[i], dir_b[i], 1'b0);
            wait_rdy("directed");
        end

        start_div(32'd100, 32'd7, 1'b0);
        rdy_before = n_rdy;
        repeat (9) @(negedge clock);
        start_div(32'd50, 32'd5, 1'b1);
        wait_rdy("restart");
        repeat (2) @(negedge clock);
        chk("restart_rdy_count", W'(n_rdy - rdy_before), 1);
        chk("restart_result_held", data_result, 32'd10);

        start_div(32'd100, 32'd7, 1'b0);
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midreset_result", data_result, '0);
        chk("midreset_exception", W'(data_exception), '0);
        chk("midreset_rdy", W'(data_resultRDY), '0);
        sb_q.delete();
        rdy_before = n_rdy;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("no_rdy_after_reset", W'(n_rdy - rdy_before), '0);
        start_div(32'd9, 32'd3, 1'b0);
        wait_rdy("post_reset");

        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = {W{1'b1}};
                2: a = MIN_INT;
                3: begin
                    a = W'($signed($urandom_range(0, 200)) - 100);
                    b = W'($signed($urandom_range(0, 20)) - 10);
                end
                4: b = W'($urandom_range(1, 1000));
                default: ;
            endcase
            start_div(a, b, 1'b0);
            wait_rdy("random");
        end

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", W'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
